// File: rtl/i2c_apb_regfile.sv
// APB register file fronting an I2C core: control/address/count registers, TX and RX FIFOs, sticky status.
// Optional macro I2C_REGFILE_IRQ_EN adds the IRQ_EN register at 0x18 and the irq_o output.
module i2c_apb_regfile #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 8
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSELx,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [7:0]        PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic              PREADY,
  output logic [DATA_W-1:0] PRDATA,
  output logic              start_o,
  output logic              rw_o,
  output logic [6:0]        saddr_o,
  output logic [7:0]        cnt_o,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  input  logic              busy_i,
  input  logic              ack_err_i
`ifdef I2C_REGFILE_IRQ_EN
  ,
  output logic              irq_o
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_SADDR  = 8'h04;
  localparam logic [7:0] A_CNT    = 8'h08;
  localparam logic [7:0] A_TXDATA = 8'h0C;
  localparam logic [7:0] A_RXDATA = 8'h10;
  localparam logic [7:0] A_STATUS = 8'h14;
`ifdef I2C_REGFILE_IRQ_EN
  localparam logic [7:0] A_IRQEN  = 8'h18;
`endif

  logic w_access, w_wr, w_rd;
  logic w_wr_ctrl, w_wr_saddr, w_wr_cnt, w_wr_tx, w_wr_stat, w_rd_rx;

  assign w_access   = PSELx & PENABLE;
  assign w_wr       = w_access & PWRITE;
  assign w_rd       = w_access & ~PWRITE;
  assign w_wr_ctrl  = w_wr & (PADDR == A_CTRL);
  assign w_wr_saddr = w_wr & (PADDR == A_SADDR);
  assign w_wr_cnt   = w_wr & (PADDR == A_CNT);
  assign w_wr_tx    = w_wr & (PADDR == A_TXDATA);
  assign w_wr_stat  = w_wr & (PADDR == A_STATUS);
  assign w_rd_rx    = w_rd & (PADDR == A_RXDATA);

  assign PREADY = 1'b1;

  logic       r_en, r_rw, r_start;
  logic [6:0] r_saddr;
  logic [7:0] r_cnt;
  logic       r_ack_err, r_tx_ovf, r_rx_udf;

  // ---- TX FIFO ----
  logic [DATA_W-1:0] r_tx_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_tx_wptr, r_tx_rptr;
  logic [CW-1:0]     r_tx_cnt, w_tx_cnt_nxt;
  logic              w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;

  assign w_tx_full    = (r_tx_cnt == CW'(FIFO_DEPTH));
  assign w_tx_empty   = (r_tx_cnt == '0);
  assign w_tx_push    = w_wr_tx & ~w_tx_full;
  assign w_tx_pop     = tx_valid_o & tx_ready_i;
  assign w_tx_cnt_nxt = r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);
  assign tx_valid_o   = ~w_tx_empty;
  assign tx_data_o    = r_tx_mem[r_tx_rptr];

  always_ff @(posedge PCLK) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= PWDATA;
  end

  // Flush while disabled takes priority over any push/pop in the same cycle.
  always_ff @(posedge PCLK) begin
    if (!PRESETn || !r_en) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_tx_cnt  <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + AW'(1);
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + AW'(1);
      r_tx_cnt <= w_tx_cnt_nxt;
    end
  end

  // ---- RX FIFO ----
  logic [DATA_W-1:0] r_rx_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_rx_wptr, r_rx_rptr;
  logic [CW-1:0]     r_rx_cnt;
  logic              w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;

  assign w_rx_full  = (r_rx_cnt == CW'(FIFO_DEPTH));
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_push  = rx_valid_i & ~w_rx_full;
  assign w_rx_pop   = w_rd_rx & ~w_rx_empty;

  always_ff @(posedge PCLK) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= rx_data_i;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn || !r_en) begin
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_rx_cnt  <= '0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + AW'(1);
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + AW'(1);
      r_rx_cnt <= r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
    end
  end

  // ---- control and sticky status ----
  logic w_ack_nxt, w_tovf_nxt, w_rudf_nxt;

  // A new event in the same cycle as a W1C clear keeps the bit set.
  assign w_ack_nxt  = ack_err_i | (r_ack_err & ~(w_wr_stat & PWDATA[5]));
  assign w_tovf_nxt = (w_wr_tx & w_tx_full) | (r_tx_ovf & ~(w_wr_stat & PWDATA[6]));
  assign w_rudf_nxt = (w_rd_rx & w_rx_empty) | (r_rx_udf & ~(w_wr_stat & PWDATA[7]));

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_en      <= 1'b0;
      r_rw      <= 1'b0;
      r_start   <= 1'b0;
      r_saddr   <= '0;
      r_cnt     <= '0;
      r_ack_err <= 1'b0;
      r_tx_ovf  <= 1'b0;
      r_rx_udf  <= 1'b0;
    end else begin
      r_start   <= w_wr_ctrl & PWDATA[0] & PWDATA[1] & ~busy_i;
      r_ack_err <= w_ack_nxt;
      r_tx_ovf  <= w_tovf_nxt;
      r_rx_udf  <= w_rudf_nxt;
      if (w_wr_ctrl) begin
        r_en <= PWDATA[0];
        r_rw <= PWDATA[2];
      end
      if (w_wr_saddr) r_saddr <= PWDATA[6:0];
      if (w_wr_cnt)   r_cnt   <= PWDATA[7:0];
    end
  end

  assign start_o = r_start;
  assign rw_o    = r_rw;
  assign saddr_o = r_saddr;
  assign cnt_o   = r_cnt;

  logic [7:0]        w_status_lo;
  logic [DATA_W-1:0] w_status;

  assign w_status_lo = {r_rx_udf, r_tx_ovf, r_ack_err, busy_i,
                        w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};

  // RX overflow only has a home in STATUS when the data path is wider than a byte.
  generate
    if (DATA_W > 8) begin : g_rx_ovf
      logic r_rx_ovf;
      always_ff @(posedge PCLK) begin
        if (!PRESETn) r_rx_ovf <= 1'b0;
        else          r_rx_ovf <= (rx_valid_i & w_rx_full) | (r_rx_ovf & ~(w_wr_stat & PWDATA[8]));
      end
      assign w_status = DATA_W'({r_rx_ovf, w_status_lo});
    end else begin : g_no_rx_ovf
      assign w_status = w_status_lo;
    end
  endgenerate

`ifdef I2C_REGFILE_IRQ_EN
  // Mask bits: [0] tx_empty, [1] ack_err, [2] tx_ovf, [3] rx_udf.
  logic [3:0] r_irq_mask;
  logic       r_irq;
  logic       w_tx_empty_nxt;

  assign w_tx_empty_nxt = ~r_en | (w_tx_cnt_nxt == '0);

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_irq_mask <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr & (PADDR == A_IRQEN)) r_irq_mask <= {PWDATA[7:5], PWDATA[1]};
      r_irq <= |({w_rudf_nxt, w_tovf_nxt, w_ack_nxt, w_tx_empty_nxt} & r_irq_mask);
    end
  end

  assign irq_o = r_irq;
`endif

  logic [DATA_W-1:0] w_rdata;

  always_comb begin
    w_rdata = '0;
    case (PADDR)
      A_CTRL:   w_rdata = DATA_W'({r_rw, 1'b0, r_en});
      A_SADDR:  w_rdata = DATA_W'(r_saddr);
      A_CNT:    w_rdata = DATA_W'(r_cnt);
      A_RXDATA: w_rdata = w_rx_empty ? '0 : r_rx_mem[r_rx_rptr];
      A_STATUS: w_rdata = w_status;
`ifdef I2C_REGFILE_IRQ_EN
      A_IRQEN:  w_rdata = DATA_W'({r_irq_mask[3:1], 3'b000, r_irq_mask[0], 1'b0});
`endif
      default:  w_rdata = '0;
    endcase
  end

  assign PRDATA = w_rd ? w_rdata : '0;

endmodule

// File: tb/tb_i2c_apb_regfile.sv
// Scoreboard bench for i2c_apb_regfile: a queue-based reference model predicts reads, TX pops and start pulses.
module tb_i2c_apb_regfile;

  localparam int D = 4;

  logic       PCLK = 1'b0;
  logic       PRESETn, PSELx, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA;
  logic       PREADY;
  logic [7:0] PRDATA;
  logic       start_o, rw_o;
  logic [6:0] saddr_o;
  logic [7:0] cnt_o, tx_data_o;
  logic       tx_valid_o, tx_ready_i;
  logic [7:0] rx_data_i;
  logic       rx_valid_i, busy_i, ack_err_i;
`ifdef I2C_REGFILE_IRQ_EN
  logic       irq_o;
`endif

  i2c_apb_regfile #(.FIFO_DEPTH(D), .DATA_W(8)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(PSELx), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY),
    .PRDATA(PRDATA), .start_o(start_o), .rw_o(rw_o), .saddr_o(saddr_o),
    .cnt_o(cnt_o), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .busy_i(busy_i), .ack_err_i(ack_err_i)
`ifdef I2C_REGFILE_IRQ_EN
    , .irq_o(irq_o)
`endif
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  always @(posedge PCLK) cyc_n <= cyc_n + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: registers as plain bits, FIFOs as queues.
  bit         m_en, m_rw, m_ack, m_tovf, m_rudf;
  bit   [6:0] m_saddr;
  bit   [7:0] m_cnt;
  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];

  logic [7:0] exp_rd[$];
  string      exp_nm[$];
  logic [7:0] exp_tx[$];
  int         exp_start[$];

  bit         force_en = 0;
  logic [7:0] force_val = '0;
  string      rd_name = "rd";

  function automatic logic [7:0] m_status();
    return {m_rudf, m_tovf, m_ack, busy_i, m_rx.size() == 0, m_rx.size() == D,
            m_tx.size() == 0, m_tx.size() == D};
  endfunction

  function automatic logic [7:0] m_read(input logic [7:0] a);
    case (a)
      8'h00:   return {5'b0, m_rw, 1'b0, m_en};
      8'h04:   return {1'b0, m_saddr};
      8'h08:   return m_cnt;
      8'h10:   return (m_rx.size() == 0) ? 8'h00 : m_rx[0];
      8'h14:   return m_status();
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_reset();
    m_en = 0; m_rw = 0; m_ack = 0; m_tovf = 0; m_rudf = 0;
    m_saddr = '0; m_cnt = '0;
    m_tx.delete(); m_rx.delete();
  endtask

  task automatic m_update(input bit wr, input bit rd);
    bit txf, rxf, rxe, clr;
    txf = (m_tx.size() == D);
    rxf = (m_rx.size() == D);
    rxe = (m_rx.size() == 0);
    clr = wr && (PADDR == 8'h14);
    m_ack  = ack_err_i | (m_ack & !(clr & PWDATA[5]));
    m_tovf = (wr && PADDR == 8'h0C && txf) | (m_tovf & !(clr & PWDATA[6]));
    m_rudf = (rd && PADDR == 8'h10 && rxe) | (m_rudf & !(clr & PWDATA[7]));
    if (!m_en) begin
      m_tx.delete();
      m_rx.delete();
    end else begin
      if (tx_ready_i && m_tx.size() > 0) void'(m_tx.pop_front());
      if (wr && PADDR == 8'h0C && !txf) m_tx.push_back(PWDATA);
      if (rd && PADDR == 8'h10 && !rxe) void'(m_rx.pop_front());
      if (rx_valid_i && !rxf) m_rx.push_back(rx_data_i);
    end
    if (wr) begin
      case (PADDR)
        8'h00: begin m_en = PWDATA[0]; m_rw = PWDATA[2]; end
        8'h04: m_saddr = PWDATA[6:0];
        8'h08: m_cnt = PWDATA;
        default: ;
      endcase
    end
  endtask

  // One clock: predict this cycle's observable outputs, then advance the model at the edge.
  task automatic cyc();
    bit wr, rd;
    wr = PSELx && PENABLE && PWRITE;
    rd = PSELx && PENABLE && !PWRITE;
    if (PRESETn) begin
      if (rd) begin
        exp_rd.push_back(force_en ? force_val : m_read(PADDR));
        exp_nm.push_back(rd_name);
      end
      if (tx_ready_i && m_tx.size() > 0) exp_tx.push_back(m_tx[0]);
      if (wr && PADDR == 8'h00 && PWDATA[1:0] == 2'b11 && !busy_i) exp_start.push_back(cyc_n + 1);
    end
    @(posedge PCLK);
    if (!PRESETn) m_reset();
    else          m_update(wr, rd);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    PSELx = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
    cyc();
    PENABLE = 1;
    cyc();
    PSELx = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic rd(input logic [7:0] a, input bit f, input logic [7:0] fv, input string nm);
    PSELx = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
    cyc();
    PENABLE = 1; force_en = f; force_val = fv; rd_name = nm;
    cyc();
    force_en = 0; rd_name = "rd";
    PSELx = 0; PENABLE = 0;
  endtask

  // Monitor: compares whatever the DUT presents against the head of the matching queue.
  always @(negedge PCLK) begin
    if (PSELx && PENABLE && !PWRITE) begin
      if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
      else check(exp_nm.pop_front(), PRDATA, exp_rd.pop_front());
    end
    if (tx_valid_o && tx_ready_i) begin
      if (exp_tx.size() == 0) check("tx_pop_unexpected", 1, 0);
      else check("tx_pop_data", tx_data_o, exp_tx.pop_front());
    end
    if (start_o) begin
      if (exp_start.size() == 0) check("start_unexpected", cyc_n, 0);
      else check("start_cycle", cyc_n, exp_start.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] addrs [8];
    logic [7:0] a, d;
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20, 8'hFF};
    PRESETn = 0; PSELx = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
    tx_ready_i = 0; rx_data_i = 0; rx_valid_i = 0; busy_i = 0; ack_err_i = 0;
    m_reset();
    repeat (3) cyc();
    PRESETn = 1;

    check("rst_pready", PREADY, 1);
    check("rst_prdata", PRDATA, 0);
    check("rst_start", start_o, 0);
    check("rst_tx_valid", tx_valid_o, 0);
    check("rst_saddr", saddr_o, 0);
    rd(8'h14, 1, 8'h0A, "rst_status");

    // TX fill, overflow, drain order
    wr(8'h00, 8'h01);
    for (int i = 0; i < 5; i++) wr(8'h0C, 8'hA1 + 8'(i));
    rd(8'h14, 1, 8'h49, "tx_full_ovf_status");
    tx_ready_i = 1;
    repeat (4) cyc();
    tx_ready_i = 0;
    check("tx_drained_valid", tx_valid_o, 0);
    rd(8'h14, 1, 8'h4A, "tx_empty_ovf_status");
    wr(8'h14, 8'h40);
    rd(8'h14, 1, 8'h0A, "tx_ovf_cleared");

    // start pulse
    wr(8'h00, 8'h03);
    check("start_pulse_hi", start_o, 1);
    cyc();
    check("start_pulse_lo", start_o, 0);
    busy_i = 1;
    wr(8'h00, 8'h03);
    check("start_busy_blocked", start_o, 0);
    busy_i = 0;
    rd(8'h00, 1, 8'h01, "ctrl_start_reads_0");

    // RX single entry and underflow
    rx_valid_i = 1; rx_data_i = 8'h5C;
    cyc();
    rx_valid_i = 0;
    rd(8'h10, 1, 8'h5C, "rx_data");
    rd(8'h10, 1, 8'h00, "rx_underflow_data");
    rd(8'h14, 1, 8'h8A, "rx_udf_status");
    wr(8'h14, 8'h80);
    rd(8'h14, 1, 8'h0A, "rx_udf_cleared");

    // TX write while full in the same cycle as a pop
    for (int i = 0; i < 4; i++) wr(8'h0C, 8'hB1 + 8'(i));
    PSELx = 1; PENABLE = 0; PWRITE = 1; PADDR = 8'h0C; PWDATA = 8'hB5;
    cyc();
    PENABLE = 1; tx_ready_i = 1;
    cyc();
    tx_ready_i = 0; PSELx = 0; PENABLE = 0; PWRITE = 0;
    rd(8'h14, 1, 8'h48, "full_push_pop_status");
    tx_ready_i = 1;
    repeat (3) cyc();
    tx_ready_i = 0;
    wr(8'h14, 8'h40);

    // ack_err sticky, set wins over clear
    ack_err_i = 1;
    cyc();
    ack_err_i = 0;
    rd(8'h14, 1, 8'h2A, "ack_err_set");
    PSELx = 1; PENABLE = 0; PWRITE = 1; PADDR = 8'h14; PWDATA = 8'h20;
    cyc();
    PENABLE = 1; ack_err_i = 1;
    cyc();
    ack_err_i = 0; PSELx = 0; PENABLE = 0; PWRITE = 0;
    rd(8'h14, 1, 8'h2A, "ack_err_set_beats_clear");
    wr(8'h14, 8'h20);
    rd(8'h14, 1, 8'h0A, "ack_err_cleared");

    // RX full, extra push dropped
    rx_valid_i = 1;
    for (int i = 0; i < 5; i++) begin rx_data_i = 8'h10 + 8'(i); cyc(); end
    rx_valid_i = 0;
    rd(8'h14, 1, 8'h06, "rx_full_status");
    for (int i = 0; i < 4; i++) rd(8'h10, 1, 8'h10 + 8'(i), "rx_full_order");
    rd(8'h10, 1, 8'h00, "rx_drop_check");
    wr(8'h14, 8'h80);

    // register mirrors and unmapped space
    wr(8'h04, 8'hFF);
    check("saddr_mirror", saddr_o, 7'h7F);
    rd(8'h04, 1, 8'h7F, "saddr_read");
    wr(8'h08, 8'h96);
    check("cnt_mirror", cnt_o, 8'h96);
    wr(8'h00, 8'h05);
    check("rw_mirror", rw_o, 1);
    rd(8'h00, 1, 8'h05, "ctrl_read");
    wr(8'h20, 8'hFF);
    rd(8'h20, 1, 8'h00, "unmapped_read");
    rd(8'h0C, 1, 8'h00, "txdata_wo_read");
`ifndef I2C_REGFILE_IRQ_EN
    rd(8'h18, 1, 8'h00, "irqen_unmapped");
`endif
    rd(8'h14, 1, 8'h0A, "status_after_unmapped_wr");

    // EN=0 flushes both FIFOs
    wr(8'h0C, 8'h11); wr(8'h0C, 8'h22);
    rx_valid_i = 1; rx_data_i = 8'h77; cyc(); rx_valid_i = 0;
    wr(8'h00, 8'h00);
    rd(8'h14, 1, 8'h0A, "flush_status");
    check("flush_tx_valid", tx_valid_o, 0);
    wr(8'h00, 8'h01);

    // reset in the middle of activity, coinciding with a START write
    wr(8'h0C, 8'h33); wr(8'h0C, 8'h44);
    rx_valid_i = 1; rx_data_i = 8'h55; cyc(); rx_valid_i = 0;
    PSELx = 1; PENABLE = 0; PWRITE = 1; PADDR = 8'h00; PWDATA = 8'h03;
    cyc();
    PENABLE = 1; PRESETn = 0;
    cyc();
    PRESETn = 1; PSELx = 0; PENABLE = 0; PWRITE = 0;
    check("midrst_tx_valid", tx_valid_o, 0);
    check("midrst_no_start", start_o, 0);
    rd(8'h14, 1, 8'h0A, "midrst_status");
    rd(8'h00, 1, 8'h00, "midrst_ctrl");
    wr(8'h00, 8'h01);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      tx_ready_i = 1'($urandom_range(0, 1));
      rx_valid_i = ($urandom_range(0, 2) == 0);
      rx_data_i  = 8'($urandom);
      busy_i     = ($urandom_range(0, 3) == 0);
      ack_err_i  = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0: cyc();
        1: begin
          a = addrs[$urandom_range(0, 7)];
          d = 8'($urandom);
          if (a == 8'h00 && $urandom_range(0, 9) != 0) d[0] = 1'b1;
          wr(a, d);
        end
        default: rd(addrs[$urandom_range(0, 7)], 0, 8'h00, "rand_rd");
      endcase
      check("rand_rw_mirror", rw_o, m_rw);
      check("rand_saddr_mirror", saddr_o, m_saddr);
      check("rand_cnt_mirror", cnt_o, m_cnt);
      check("rand_tx_valid", tx_valid_o, m_tx.size() != 0);
    end
    tx_ready_i = 0; rx_valid_i = 0; busy_i = 0; ack_err_i = 0;
    repeat (2) cyc();

`ifdef I2C_REGFILE_IRQ_EN
    wr(8'h14, 8'hE0);
    wr(8'h18, 8'h20);
    cyc();
    check("irq_idle", irq_o, 0);
    ack_err_i = 1;
    cyc();
    ack_err_i = 0;
    check("irq_set", irq_o, 1);
    wr(8'h14, 8'h20);
    check("irq_cleared", irq_o, 0);
`endif

    repeat (3) cyc();
    check("rd_queue_left", exp_rd.size(), 0);
    check("tx_queue_left", exp_tx.size(), 0);
    check("start_queue_left", exp_start.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
